tri_cull: RTL

TRI_CULL -- requirements
Module: tri_cull

---
 rtl/tri_cull.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tri_cull.sv
// Three-stage back-face / off-screen triangle culler feeding a downstream FIFO.
// Define TRI_CULL_STATS_EN to add the per-frame pass/cull statistics counters.
`timescale 1ns / 1ps

module tri_cull #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [59:0] tri_in,
    input  logic        fifo_full,
    output logic        fifo_w,
    output logic [59:0] tri_out,
    output logic        busy
`ifdef TRI_CULL_STATS_EN
    ,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  cull_cnt
`endif
);

    // Triangle word: vertex v occupies [v*20 +: 20], X in the low 10 bits, Y above it.
    function automatic logic [9:0] px(input logic [59:0] t, input int unsigned v,
                                      input int unsigned c);
        return t[v*20 + c*10 +: 10];
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic [59:0]        s1_tri_q, s1_tri_d;
    logic               s2_valid_q, s2_valid_d;
    logic [59:0]        s2_tri_q, s2_tri_d;
    logic signed [10:0] s2_e1x_q, s2_e1x_d, s2_e1y_q, s2_e1y_d;
    logic signed [10:0] s2_e2x_q, s2_e2x_d, s2_e2y_q, s2_e2y_d;
    logic               s3_valid_q, s3_valid_d;
    logic [59:0]        s3_tri_q, s3_tri_d;
    logic signed [21:0] s3_c_q, s3_c_d;

    logic               adv;
    logic               accept;
    logic               s3_pass;
    logic               on_x, on_y;
    logic signed [10:0] e1x, e1y, e2x, e2y;
    logic signed [21:0] prod_a, prod_b;

    // Edge vectors from the S1 triangle; zero-extending keeps the 11-bit difference exact.
    always_comb begin
        e1x = {1'b0, px(s1_tri_q, 1, 0)} - {1'b0, px(s1_tri_q, 0, 0)};
        e1y = {1'b0, px(s1_tri_q, 1, 1)} - {1'b0, px(s1_tri_q, 0, 1)};
        e2x = {1'b0, px(s1_tri_q, 2, 0)} - {1'b0, px(s1_tri_q, 0, 0)};
        e2y = {1'b0, px(s1_tri_q, 2, 1)} - {1'b0, px(s1_tri_q, 0, 1)};
    end

    // |e| <= 1023, so each product and their difference fit in 22 signed bits.
    always_comb begin
        prod_a = 22'(s2_e1x_q) * 22'(s2_e2y_q);
        prod_b = 22'(s2_e1y_q) * 22'(s2_e2x_q);
    end

    always_comb begin
        on_x = 1'b0;
        on_y = 1'b0;
        for (int unsigned v = 0; v < 3; v++) begin
            if (32'(px(s3_tri_q, v, 0)) < SCREEN_W) on_x = 1'b1;
            if (32'(px(s3_tri_q, v, 1)) < SCREEN_H) on_y = 1'b1;
        end
        s3_pass = ~s3_c_q[21] & (s3_c_q != '0) & on_x & on_y;
    end

    // Only a passing triangle blocked by a full FIFO stalls; culled ones drain freely.
    assign adv       = ~(s3_valid_q & s3_pass & fifo_full);
    assign tri_ready = adv & ~frame_start;
    assign accept    = tri_valid & tri_ready;
    assign fifo_w    = s3_valid_q & s3_pass & ~fifo_full & ~frame_start;
    assign tri_out   = s3_tri_q;
    assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tri_d   = s1_tri_q;
        s2_valid_d = s2_valid_q;
        s2_tri_d   = s2_tri_q;
        s2_e1x_d   = s2_e1x_q;
        s2_e1y_d   = s2_e1y_q;
        s2_e2x_d   = s2_e2x_q;
        s2_e2y_d   = s2_e2y_q;
        s3_valid_d = s3_valid_q;
        s3_tri_d   = s3_tri_q;
        s3_c_d     = s3_c_q;
        if (frame_start) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
        end else if (adv) begin
            s1_valid_d = accept;
            if (accept) s1_tri_d = tri_in;
            s2_valid_d = s1_valid_q;
            s2_tri_d   = s1_tri_q;
            s2_e1x_d   = e1x;
            s2_e1y_d   = e1y;
            s2_e2x_d   = e2x;
            s2_e2y_d   = e2y;
            s3_valid_d = s2_valid_q;
            s3_tri_d   = s2_tri_q;
            s3_c_d     = prod_a - prod_b;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_tri_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_tri_q   <= '0;
            s2_e1x_q   <= '0;
            s2_e1y_q   <= '0;
            s2_e2x_q   <= '0;
            s2_e2y_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_tri_q   <= '0;
            s3_c_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tri_q   <= s1_tri_d;
            s2_valid_q <= s2_valid_d;
            s2_tri_q   <= s2_tri_d;
            s2_e1x_q   <= s2_e1x_d;
            s2_e1y_q   <= s2_e1y_d;
            s2_e2x_q   <= s2_e2x_d;
            s2_e2y_q   <= s2_e2y_d;
            s3_valid_q <= s3_valid_d;
            s3_tri_q   <= s3_tri_d;
            s3_c_q     <= s3_c_d;
        end
    end

`ifdef TRI_CULL_STATS_EN
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] cull_cnt_q, cull_cnt_d;
    logic       discard;

    assign discard = s3_valid_q & ~s3_pass & ~frame_start;

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        cull_cnt_d = cull_cnt_q;
        if (frame_start) begin
            pass_cnt_d = '0;
            cull_cnt_d = '0;
        end else begin
            if (fifo_w && pass_cnt_q != 8'hff) pass_cnt_d = pass_cnt_q + 8'd1;
            if (discard && cull_cnt_q != 8'hff) cull_cnt_d = cull_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pass_cnt_q <= '0;
            cull_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            cull_cnt_q <= cull_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign cull_cnt = cull_cnt_q;
`endif

endmodule
